load_unit: RTL and testbench

//  Multicycle load execution unit for the kianv rv32im core. Consumes the LOADop

---
 rtl/load_unit.sv | 151 +++++++++++++++
 tb/tb_load_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Multicycle load unit: one aligned bus read per load,
// then byte/half/word extraction with sign or zero extension.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned LOAD_OP_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [LOAD_OP_WIDTH-1:0] LOADop,
  input  logic [31:0]              addr,
  output logic                     busy,
  output logic                     mem_valid,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic [31:0]              result,
  output logic                     done,
  output logic                     misaligned,
  output logic                     timeout
);

  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = LOAD_OP_WIDTH'(0);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = LOAD_OP_WIDTH'(1);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = LOAD_OP_WIDTH'(2);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = LOAD_OP_WIDTH'(3);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = LOAD_OP_WIDTH'(4);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic       TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t                   state;
  logic [7:0]               count;
  logic [LOAD_OP_WIDTH-1:0] op_q;
  logic [1:0]               off_q;

  logic                     op_ok;
  logic                     bad_align;
  logic                     to_hit;
  logic [7:0]               byte_sel;
  logic [15:0]              half_sel;
  logic [31:0]              ext;

  always_comb begin
    op_ok     = 1'b0;
    bad_align = 1'b0;
    unique case (LOADop)
      LOAD_OP_LB,
      LOAD_OP_LBU: op_ok = 1'b1;
      LOAD_OP_LH,
      LOAD_OP_LHU: begin
        op_ok     = 1'b1;
        bad_align = addr[0];
      end
      LOAD_OP_LW: begin
        op_ok     = 1'b1;
        bad_align = |addr[1:0];
      end
      default: op_ok = 1'b0;
    endcase
  end

  // Abort on the cycle whose missing ready would bring count to the limit.
  assign to_hit = TO_EN && (count == TO_LIMIT - 8'd1);

  assign byte_sel = mem_rdata[8*off_q +: 8];
  assign half_sel = mem_rdata[16*off_q[1] +: 16];

  always_comb begin
    ext = mem_rdata;
    unique case (op_q)
      LOAD_OP_LB:  ext = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_LBU: ext = {24'b0, byte_sel};
      LOAD_OP_LH:  ext = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_LHU: ext = {16'b0, half_sel};
      default:     ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      count      <= 8'd0;
      op_q       <= '0;
      off_q      <= 2'b00;
      busy       <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'd0;
      result     <= 32'd0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && op_ok) begin
            op_q     <= LOADop;
            off_q    <= addr[1:0];
            mem_addr <= {addr[31:2], 2'b00};
            count    <= 8'd0;
            busy     <= 1'b1;
            if (bad_align) begin
              state      <= DONE;
              result     <= 32'd0;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state     <= DONE;
            mem_valid <= 1'b0;
            result    <= ext;
            done      <= 1'b1;
          end else if (to_hit) begin
            state     <= DONE;
            mem_valid <= 1'b0;
            result    <= 32'd0;
            done      <= 1'b1;
            timeout   <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Randomized scoreboard bench for load_unit.
// Driver pushes expected completions; monitor pops on done.
module tb_load_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  LOADop;
  logic [31:0] addr;
  logic        busy;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] result;
  logic        done;
  logic        misaligned;
  logic        timeout;

  load_unit #(
    .TIMEOUT_CYCLES(T),
    .LOAD_OP_WIDTH(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .LOADop(LOADop),
    .addr(addr),
    .busy(busy),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .result(result),
    .done(done),
    .misaligned(misaligned),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        mis;
    logic        to;
    logic [31:0] maddr;
    int          lat;
    int          c0;
    bit          abandon;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] rd, input int waits);
    exp_t e;
    int   off;
    int   v;
    off = int'(a[1:0]);
    v = 0;
    e.abandon = 0;
    e.maddr = a - (a % 4);
    e.to = 0;
    e.mis = ((op == 1 || op == 4) && (off % 2 != 0)) || (op == 2 && off != 0);
    case (op)
      0: begin v = int'((rd >> (8 * off)) & 32'hFF); if (v >= 128) v -= 256; end
      3: v = int'((rd >> (8 * off)) & 32'hFF);
      1: begin
        v = int'((rd >> (16 * (off / 2))) & 32'hFFFF);
        if (v >= 32768) v -= 65536;
      end
      4: v = int'((rd >> (16 * (off / 2))) & 32'hFFFF);
      default: v = int'(rd);
    endcase
    e.res = 32'(v);
    if (e.mis) begin
      e.res = 0;
      e.lat = 1;
    end else if (waits >= T) begin
      e.res = 0;
      e.to = 1;
      e.lat = T + 1;
    end else begin
      e.lat = waits + 2;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mem_valid) begin
      if (q.size() == 0) begin
        chk("mem_valid_unexpected", {31'b0, mem_valid}, 32'd0);
      end else begin
        chk("mem_addr", mem_addr, q[0].maddr);
        chk("mem_valid_on_misaligned", {31'b0, q[0].mis}, 32'd0);
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        chk("done_unexpected", {31'b0, done}, 32'd0);
      end else if (q[0].abandon) begin
        chk("done_after_reset", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
        chk("timeout", {31'b0, timeout}, {31'b0, e.to});
        chk("latency", 32'(cyc - e.c0), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_bound", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] rd, input int waits,
                         input bit noise);
    exp_t e;
    bit   legal;
    legal = (op < 5);
    e = model(op, a, rd, waits);
    @(negedge clk);
    start = 1'b1;
    LOADop = op;
    addr = a;
    mem_rdata = $urandom;
    e.c0 = cyc;
    if (legal) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    addr = $urandom;
    LOADop = 3'($urandom);
    if (!legal) begin
      chk("illegal_ignored", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      return;
    end
    if (!e.mis) begin
      for (int i = 0; i <= waits && i < T; i++) begin
        if (i == waits) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end else if (noise) begin
          start = 1'($urandom);
          LOADop = 3'($urandom_range(0, 4));
          addr = $urandom;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        start = 1'b0;
        mem_rdata = $urandom;
      end
    end
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    resetn = 1'b0;
    start = 1'b0;
    LOADop = 3'd0;
    addr = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'b0, misaligned, timeout}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    do_load(3'd0, 32'h103, 32'h80AABBCC, 0, 0);
    chk("t1_result", result, 32'hFFFFFF80);
    do_load(3'd1, 32'h202, 32'h80011234, 0, 0);
    chk("t2_lh", result, 32'hFFFF8001);
    do_load(3'd4, 32'h202, 32'h80011234, 1, 0);
    chk("t2_lhu", result, 32'h00008001);
    do_load(3'd2, 32'h006, 32'hDEADBEEF, 0, 0);
    chk("t3_result", result, 32'h0);
    do_load(3'd2, 32'h10, 32'h12345678, 0, 0);
    do_load(3'd2, 32'h20, 32'h12345678, T, 0);
    chk("t4_result", result, 32'h0);
    do_load(3'd3, 32'h41, 32'hA5C3E7F1, 3, 1);
    chk("t5_result", result, 32'h000000E7);
    do_load(3'd5, 32'h44, 32'h0, 0, 0);
    do_load(3'd7, 32'h48, 32'h0, 0, 0);

    e = model(3'd2, 32'h300, 32'h0, 0);
    e.abandon = 1;
    @(negedge clk);
    start = 1'b1;
    LOADop = 3'd2;
    addr = 32'h300;
    e.c0 = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    void'(q.pop_front());
    chk("rst_req_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_req_busy", {31'b0, busy}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_no_done", {31'b0, done}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      do_load(3'($urandom_range(0, 6)), $urandom, $urandom,
              int'($urandom_range(0, 5)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
